zxuno_msgsink: RTL and testbench

- Write-direction counterpart of the read-only ID-string register.
- The CPU streams bytes into one ZXUNO register address; the block packs them into a 2^AW-byte buffer.
- A message completes on a 0x00 terminator or when the buffer is full.
- A core-side consumer then reads the message by index and releases it with an ack.
- Sits beside the other ZXUNO register-file peripherals, on the shared zxuno_addr/regwr/regrd bus.

---
 rtl/zxuno_msgsink_pkg.sv | 16 +
 rtl/msgsink_buf.sv | 33 +++
 rtl/zxuno_msgsink.sv | 152 +++++++++++++++
 tb/tb_zxuno_msgsink.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zxuno_msgsink_pkg.sv
// Shared types and constants for the ZXUNO message sink: FSM states, status-byte layout, default address.
package zxuno_msgsink_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int ST_VALID_BIT = 7;
    localparam int ST_OVF_BIT   = 6;
    localparam int ST_HOLD_BIT  = 5;
    localparam int ST_LEN_MSB   = 4;

    localparam logic [7:0] MSGADDR_DEFAULT = 8'hF0;

endpackage

// File: rtl/msgsink_buf.sv
// Message buffer: 2^AW x 8 simple dual-port RAM, one write port, registered read port.
// Latency: rdata one clk after raddr. No backpressure.
// Backpressure: none; a write lands every cycle we is high.
module msgsink_buf #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    // Array left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/zxuno_msgsink.sv
// CPU-written message sink on the ZXUNO register bus; packs bytes until 0x00 or full, then holds for the core.
// Latency: byte commits on the clk the write strobe drops; rd_data and dout are registered (1 clk).
// Backpressure: writes while holding are dropped and flagged sticky; ZXUNO_MSGSINK_READBACK_EN enables status reads.
module zxuno_msgsink
    import zxuno_msgsink_pkg::*;
#(
    parameter logic [7:0] MSGADDR = MSGADDR_DEFAULT,
    parameter int         AW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    zxuno_addr,
    input  logic          zxuno_regwr,
    input  logic          zxuno_regrd,
    input  logic          regaddr_changed,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          oe,
    output logic          msg_valid,
    output logic [AW:0]   msg_len,
    output logic          msg_overflow,
    input  logic [AW-1:0] rd_idx,
    output logic [7:0]    rd_data,
    input  logic          msg_ack
);

    localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};

    state_t        state_q, state_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [AW:0]   len_q, len_d;
    logic          ovf_q, ovf_d;
    logic          writing_q;
    logic [7:0]    wbyte_q;
    logic          sel, commit, addr_clr, buf_we;

    assign sel      = (zxuno_addr == MSGADDR);
    assign commit   = writing_q && !zxuno_regwr;
    assign addr_clr = regaddr_changed && sel;

    // One byte per CPU OUT: latch on the strobe's first cycle, commit when it drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writing_q <= 1'b0;
            wbyte_q   <= 8'h00;
        end else if (addr_clr || commit) begin
            writing_q <= 1'b0;
        end else if (sel && zxuno_regwr && !writing_q) begin
            writing_q <= 1'b1;
            wbyte_q   <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            wr_idx_q <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        buf_we   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (addr_clr) begin
                    wr_idx_d = '0;
                end else if (commit) begin
                    if (wbyte_q == 8'h00) begin
                        if (wr_idx_q != '0) begin
                            state_d = HOLD;
                            len_d   = {1'b0, wr_idx_q};
                        end
                    end else begin
                        buf_we   = 1'b1;
                        wr_idx_d = wr_idx_q + 1'b1;
                        if (&wr_idx_q) begin
                            state_d = HOLD;
                            len_d   = FULL_LEN;
                        end
                    end
                end
            end
            HOLD: begin
                // The ack outranks a coincident write, which is dropped silently.
                if (msg_ack) begin
                    state_d  = COLLECT;
                    wr_idx_d = '0;
                    ovf_d    = 1'b0;
                end else if (commit && !addr_clr) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign msg_valid    = (state_q == HOLD);
    assign msg_len      = len_q;
    assign msg_overflow = ovf_q;

    msgsink_buf #(.AW(AW)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (wr_idx_q),
        .wdata (wbyte_q),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

`ifdef ZXUNO_MSGSINK_READBACK_EN
    logic [7:0] len_ext;
    logic [7:0] status;

    assign len_ext = 8'(len_q);

    always_comb begin
        status                 = 8'h00;
        status[ST_VALID_BIT]   = msg_valid;
        status[ST_OVF_BIT]     = ovf_q;
        status[ST_HOLD_BIT]    = (state_q == HOLD);
        status[ST_LEN_MSB:0]   = len_ext[ST_LEN_MSB:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 8'h00;
        end else begin
            dout <= status;
        end
    end

    assign oe = sel && zxuno_regrd;
`else
    logic unused_regrd;
    assign unused_regrd = zxuno_regrd;
    assign dout         = 8'h00;
    assign oe           = 1'b0;
`endif

endmodule

// File: tb/tb_zxuno_msgsink.sv
// Randomized and directed bench for zxuno_msgsink, checked against a message-level reference model.
module tb_zxuno_msgsink;

    localparam logic [7:0] ADDR  = 8'hF0;
    localparam int         AW    = 4;
    localparam int         DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    zxuno_addr;
    logic          zxuno_regwr;
    logic          zxuno_regrd;
    logic          regaddr_changed;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          oe;
    logic          msg_valid;
    logic [AW:0]   msg_len;
    logic          msg_overflow;
    logic [AW-1:0] rd_idx;
    logic [7:0]    rd_data;
    logic          msg_ack;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: message contents, completion state and sticky overflow.
    logic [7:0] mdl_buf [DEPTH];
    bit         mdl_wr  [DEPTH];
    int         mdl_idx;
    int         mdl_len;
    bit         mdl_hold;
    bit         mdl_ovf;

    always #5 clk = ~clk;

    zxuno_msgsink #(.MSGADDR(ADDR), .AW(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .zxuno_addr      (zxuno_addr),
        .zxuno_regwr     (zxuno_regwr),
        .zxuno_regrd     (zxuno_regrd),
        .regaddr_changed (regaddr_changed),
        .din             (din),
        .dout            (dout),
        .oe              (oe),
        .msg_valid       (msg_valid),
        .msg_len         (msg_len),
        .msg_overflow    (msg_overflow),
        .rd_idx          (rd_idx),
        .rd_data         (rd_data),
        .msg_ack         (msg_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        mdl_idx  = 0;
        mdl_len  = 0;
        mdl_hold = 0;
        mdl_ovf  = 0;
        for (int i = 0; i < DEPTH; i++) mdl_wr[i] = 0;
    endtask

    task automatic mdl_commit(input logic [7:0] b);
        if (mdl_hold) begin
            mdl_ovf = 1;
        end else if (b == 8'h00) begin
            if (mdl_idx > 0) begin
                mdl_hold = 1;
                mdl_len  = mdl_idx;
            end
        end else begin
            mdl_buf[mdl_idx] = b;
            mdl_wr[mdl_idx]  = 1;
            mdl_idx++;
            if (mdl_idx == DEPTH) begin
                mdl_hold = 1;
                mdl_len  = DEPTH;
                mdl_idx  = 0;
            end
        end
    endtask

    function automatic logic [7:0] exp_status();
`ifdef ZXUNO_MSGSINK_READBACK_EN
        return {mdl_hold, mdl_ovf, mdl_hold, 5'(mdl_len)};
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic exp_oe();
`ifdef ZXUNO_MSGSINK_READBACK_EN
        return (zxuno_addr == ADDR) && zxuno_regrd;
`else
        return 1'b0;
`endif
    endfunction

    // One CPU OUT of b with a strobe of 'cycles' clocks; ack/chg land on the commit cycle.
    task automatic cpu_out(input logic [7:0] addr, input logic [7:0] b, input int cycles,
                           input bit ack, input bit chg);
        zxuno_addr  = addr;
        din         = b;
        zxuno_regwr = 1'b1;
        repeat (cycles) @(negedge clk);
        zxuno_regwr     = 1'b0;
        msg_ack         = ack;
        regaddr_changed = chg;
        @(negedge clk);
        msg_ack         = 1'b0;
        regaddr_changed = 1'b0;
        if (ack && mdl_hold) begin
            mdl_hold = 0;
            mdl_idx  = 0;
            mdl_ovf  = 0;
        end else if (chg && addr == ADDR) begin
            if (!mdl_hold) mdl_idx = 0;
        end else if (addr == ADDR) begin
            mdl_commit(b);
        end
    endtask

    task automatic dut_ack();
        msg_ack = 1'b1;
        @(negedge clk);
        msg_ack = 1'b0;
        if (mdl_hold) begin
            mdl_hold = 0;
            mdl_idx  = 0;
            mdl_ovf  = 0;
        end
    endtask

    task automatic addr_chg(input logic [7:0] addr);
        zxuno_addr      = addr;
        regaddr_changed = 1'b1;
        @(negedge clk);
        regaddr_changed = 1'b0;
        if (addr == ADDR && !mdl_hold) mdl_idx = 0;
    endtask

    // Extra clock so the registered status byte reflects the latest state.
    task automatic check_state(input string tag);
        zxuno_regrd = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk({tag, "_valid"}, 32'(msg_valid), 32'(mdl_hold));
        chk({tag, "_len"}, 32'(msg_len), 32'(mdl_len));
        chk({tag, "_ovf"}, 32'(msg_overflow), 32'(mdl_ovf));
        chk({tag, "_dout"}, 32'(dout), 32'(exp_status()));
        chk({tag, "_oe"}, 32'(oe), 32'(exp_oe()));
    endtask

    task automatic check_read(input string tag, input int i);
        rd_idx = AW'(i);
        @(negedge clk);
        chk(tag, 32'(rd_data), 32'(mdl_buf[i]));
    endtask

    task automatic check_all_written(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            if (mdl_wr[i]) check_read(tag, i);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        zxuno_addr      = ADDR;
        zxuno_regwr     = 1'b0;
        zxuno_regrd     = 1'b1;
        regaddr_changed = 1'b0;
        din             = 8'h00;
        rd_idx          = '0;
        msg_ack         = 1'b0;
        mdl_reset();

        #12;
        chk("rst_valid", 32'(msg_valid), 0);
        chk("rst_len", 32'(msg_len), 0);
        chk("rst_ovf", 32'(msg_overflow), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_dout", 32'(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // "AB",0 with long strobes.
        cpu_out(ADDR, 8'h41, 3, 0, 0);
        cpu_out(ADDR, 8'h42, 3, 0, 0);
        cpu_out(ADDR, 8'h00, 3, 0, 0);
        check_state("ab");
        chk("ab_len_abs", 32'(msg_len), 2);
`ifdef ZXUNO_MSGSINK_READBACK_EN
        chk("ab_status_abs", 32'(dout), 32'h A2);
`endif
        check_read("ab_rd0", 0);
        check_read("ab_rd1", 1);
        chk("ab_rd1_abs", 32'(rd_data), 32'h42);
        dut_ack();

        // Fill the buffer exactly.
        for (int i = 1; i <= DEPTH; i++) begin
            cpu_out(ADDR, 8'(i), 1, 0, 0);
            if (i == DEPTH - 1) check_state("fill_pre");
        end
        check_state("fill");
        chk("fill_len_abs", 32'(msg_len), DEPTH);
        check_read("fill_rd15", DEPTH - 1);

        cpu_out(ADDR, 8'h55, 2, 0, 0);
        check_state("ovf");
        chk("ovf_abs", 32'(msg_overflow), 1);
        check_all_written("ovf_buf");
        dut_ack();
        check_state("ovf_ack");
        cpu_out(ADDR, 8'h43, 1, 0, 0);
        cpu_out(ADDR, 8'h00, 1, 0, 0);
        check_state("c");
        check_read("c_rd0", 0);
        dut_ack();

        // Address rewrite discards a partial message.
        cpu_out(ADDR, 8'h58, 2, 0, 0);
        cpu_out(ADDR, 8'h59, 2, 0, 0);
        addr_chg(ADDR);
        cpu_out(ADDR, 8'h5A, 2, 0, 0);
        cpu_out(ADDR, 8'h00, 2, 0, 0);
        check_state("chg");
        check_read("chg_rd0", 0);
        chk("chg_rd0_abs", 32'(rd_data), 32'h5A);
        dut_ack();

        // Empty message and foreign address.
        cpu_out(ADDR, 8'h00, 2, 0, 0);
        check_state("empty");
        cpu_out(8'h10, 8'h4B, 2, 0, 0);
        cpu_out(8'h10, 8'h00, 2, 0, 0);
        check_state("foreign");

        // Ack coincident with a write in HOLD.
        cpu_out(ADDR, 8'h4D, 1, 0, 0);
        cpu_out(ADDR, 8'h00, 1, 0, 0);
        cpu_out(ADDR, 8'h66, 2, 1, 0);
        check_state("ack_wr");

        // Asynchronous reset mid-strobe.
        cpu_out(ADDR, 8'h50, 1, 0, 0);
        cpu_out(ADDR, 8'h51, 1, 0, 0);
        cpu_out(ADDR, 8'h00, 1, 0, 0);
        dut_ack();
        cpu_out(ADDR, 8'h61, 1, 0, 0);
        cpu_out(ADDR, 8'h62, 1, 0, 0);
        cpu_out(ADDR, 8'h63, 1, 0, 0);
        check_read("pre_rst_rd0", 0);
        zxuno_addr  = ADDR;
        din         = 8'h99;
        zxuno_regwr = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_len", 32'(msg_len), 0);
        chk("arst_valid", 32'(msg_valid), 0);
        chk("arst_rd_data", 32'(rd_data), 0);
        chk("arst_dout", 32'(dout), 0);
        mdl_reset();
        zxuno_regwr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_out(ADDR, 8'h71, 1, 0, 0);
        cpu_out(ADDR, 8'h00, 1, 0, 0);
        check_state("post_rst");
        check_read("post_rst_rd0", 0);
        dut_ack();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int op;
            op = int'($urandom_range(0, 99));
            if (op < 70) begin
                logic [7:0] b;
                b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                cpu_out(ADDR, b, int'($urandom_range(1, 4)), 0, 0);
            end else if (op < 80) begin
                dut_ack();
            end else if (op < 86) begin
                addr_chg(($urandom_range(0, 1) == 0) ? ADDR : 8'h20);
            end else if (op < 91) begin
                cpu_out(8'h33, 8'($urandom_range(0, 255)), 2, 0, 0);
            end else if (op < 96) begin
                cpu_out(ADDR, 8'($urandom_range(0, 255)), 2, 1, 0);
            end else begin
                cpu_out(ADDR, 8'($urandom_range(0, 255)), 2, 0, 1);
            end
            check_state("rnd");
            if (mdl_hold && ($urandom_range(0, 3) == 0)) check_all_written("rnd_rd");
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
